// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings for the program-counter sequencer.
// Used by pc_target_mux and pc_sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    PCSEL_SEQ    = 2'b00,
    PCSEL_BRANCH = 2'b01,
    PCSEL_JUMP   = 2'b10,
    PCSEL_REG    = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_FAULT  = 2'b10
  } pc_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_target_mux.sv
// pc_target_mux: builds seq/branch/jump/register next-PC candidates
// and selects one; purely combinational.
module pc_target_mux
  import pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  sel,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_imm,
  input  logic [31:0] jr_target,
  output logic [31:0] pc4,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] jmp_pc;

  assign seq_pc = pc + 32'd4;
  assign br_pc  = seq_pc + {branch_offset[29:0], 2'b00};
  // Region bits come from the current PC, not PC+4.
  assign jmp_pc = {pc[31:28], jump_imm, 2'b00};
  assign pc4    = seq_pc;

  always_comb begin
    next_pc = seq_pc;
    unique case (sel)
      PCSEL_SEQ:    next_pc = seq_pc;
      PCSEL_BRANCH: next_pc = branch_taken ? br_pc : seq_pc;
      PCSEL_JUMP:   next_pc = jmp_pc;
      PCSEL_REG:    next_pc = jr_target;
      default:      next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC, retire counter and RUN/HALTED/FAULT FSM.
// Define LINK_EN to add link-register capture (link, link_pc, link_valid).
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        pc_write,
  input  logic [1:0]  sel,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_imm,
  input  logic [31:0] jr_target,
  input  logic        halt,
`ifdef LINK_EN
  input  logic        link,
  output logic [31:0] link_pc,
  output logic        link_valid,
`endif
  output logic [31:0] PC0,
  output logic [31:0] PC4,
  output logic [1:0]  state,
  output logic [31:0] fault_addr,
  output logic [31:0] retire_cnt
);

  pc_state_e   st;
  logic [31:0] next_pc;
  logic        misalign;

  pc_target_mux u_mux (
    .pc            (PC0),
    .sel           (sel),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_imm      (jump_imm),
    .jr_target     (jr_target),
    .pc4           (PC4),
    .next_pc       (next_pc)
  );

  assign misalign = (sel == PCSEL_REG) && (jr_target[1:0] != 2'b00);
  assign state    = st;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      st         <= ST_RUN;
      PC0        <= RESET_PC;
      fault_addr <= '0;
      retire_cnt <= '0;
`ifdef LINK_EN
      link_pc    <= '0;
      link_valid <= 1'b0;
`endif
    end else begin
`ifdef LINK_EN
      link_valid <= 1'b0;
`endif
      if (st == ST_RUN) begin
        // A misaligned register jump faults and outranks halt.
        if (pc_write && misalign) begin
          st         <= ST_FAULT;
          fault_addr <= jr_target;
        end else begin
          if (pc_write) begin
            PC0        <= next_pc;
            retire_cnt <= retire_cnt + 32'd1;
`ifdef LINK_EN
            if (link && sel[1]) begin
              link_pc    <= PC0 + 32'd8;
              link_valid <= 1'b1;
            end
`endif
          end
          if (halt)
            st <= ST_HALTED;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// Covers LINK_EN capture when that macro is defined.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        pc_write = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = '0;
  logic [25:0] jump_imm = '0;
  logic [31:0] jr_target = '0;
  logic        halt = 1'b0;
  logic [31:0] PC0;
  logic [31:0] PC4;
  logic [1:0]  state;
  logic [31:0] fault_addr;
  logic [31:0] retire_cnt;
`ifdef LINK_EN
  logic        link = 1'b0;
  logic [31:0] link_pc;
  logic        link_valid;
`endif

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .pc_write      (pc_write),
    .sel           (sel),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_imm      (jump_imm),
    .jr_target     (jr_target),
    .halt          (halt),
`ifdef LINK_EN
    .link          (link),
    .link_pc       (link_pc),
    .link_valid    (link_valid),
`endif
    .PC0           (PC0),
    .PC4           (PC4),
    .state         (state),
    .fault_addr    (fault_addr),
    .retire_cnt    (retire_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    pc_write = 1'b0;
    halt = 1'b0;
    cyc();
    Reset = 1'b0;
  endtask

  task automatic jr(input logic [31:0] t);
    pc_write = 1'b1;
    sel = 2'b11;
    jr_target = t;
    cyc();
    pc_write = 1'b0;
  endtask

  initial begin
    cyc();
    cyc();
    Reset = 1'b0;
    chk("rst_pc", PC0, 32'h0);
    chk("rst_pc4", PC4, 32'h4);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_fault", fault_addr, 32'h0);
    chk("rst_retire", retire_cnt, 32'h0);

    pc_write = 1'b1;
    sel = 2'b00;
    cyc();
    chk("seq1", PC0, 32'h4);
    cyc();
    chk("seq2", PC0, 32'h8);
    cyc();
    chk("seq3", PC0, 32'hC);
    chk("seq_retire", retire_cnt, 32'd3);

    pc_write = 1'b0;
    sel = 2'b10;
    jump_imm = 26'h3FFFFFF;
    cyc();
    chk("hold_pc", PC0, 32'hC);
    chk("hold_retire", retire_cnt, 32'd3);

    jr(32'h1000_0040);
    chk("jr_pc", PC0, 32'h1000_0040);
    chk("jr_retire", retire_cnt, 32'd4);

    pc_write = 1'b1;
    sel = 2'b10;
    jump_imm = 26'h0000100;
    cyc();
    pc_write = 1'b0;
    chk("jump_pc", PC0, 32'h1000_0400);

    jr(32'h0000_0100);
    pc_write = 1'b1;
    sel = 2'b01;
    branch_taken = 1'b1;
    branch_offset = 32'hFFFF_FFFC;
    cyc();
    pc_write = 1'b0;
    chk("br_taken", PC0, 32'h0000_00F4);

    jr(32'h0000_0100);
    pc_write = 1'b1;
    sel = 2'b01;
    branch_taken = 1'b0;
    cyc();
    pc_write = 1'b0;
    chk("br_not", PC0, 32'h0000_0104);
    chk("br_retire", retire_cnt, 32'd9);

    pc_write = 1'b1;
    sel = 2'b11;
    jr_target = 32'h0000_2002;
    cyc();
    chk("flt_state", {30'd0, state}, 32'd2);
    chk("flt_addr", fault_addr, 32'h0000_2002);
    chk("flt_pc", PC0, 32'h0000_0104);
    chk("flt_retire", retire_cnt, 32'd9);
    sel = 2'b00;
    halt = 1'b1;
    cyc();
    pc_write = 1'b0;
    halt = 1'b0;
    chk("flt_ign_pc", PC0, 32'h0000_0104);
    chk("flt_ign_st", {30'd0, state}, 32'd2);

    Reset = 1'b1;
    pc_write = 1'b1;
    cyc();
    Reset = 1'b0;
    pc_write = 1'b0;
    chk("rec_pc", PC0, 32'h0);
    chk("rec_state", {30'd0, state}, 32'd0);
    chk("rec_retire", retire_cnt, 32'd0);
    chk("rec_fault", fault_addr, 32'h0);

    pc_write = 1'b1;
    sel = 2'b11;
    jr_target = 32'h0000_0301;
    halt = 1'b1;
    cyc();
    pc_write = 1'b0;
    halt = 1'b0;
    chk("flt_vs_halt", {30'd0, state}, 32'd2);
    chk("flt_vs_halt_pc", PC0, 32'h0);
    do_reset();

    jr(32'hFFFF_FFFC);
    chk("wrap_pc4", PC4, 32'h0);
    pc_write = 1'b1;
    sel = 2'b00;
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    chk("wrap_pc", PC0, 32'h0);
    chk("halt_state", {30'd0, state}, 32'd1);
    chk("halt_retire", retire_cnt, 32'd2);
    cyc();
    pc_write = 1'b0;
    chk("halt_ign_pc", PC0, 32'h0);
    chk("halt_ign_ret", retire_cnt, 32'd2);
    chk("halt_ign_st", {30'd0, state}, 32'd1);
    do_reset();

`ifdef LINK_EN
    jr(32'h0040_0000);
    chk("lnk_none", {31'd0, link_valid}, 32'd0);
    pc_write = 1'b1;
    sel = 2'b10;
    jump_imm = 26'h0000000;
    link = 1'b1;
    cyc();
    pc_write = 1'b0;
    link = 1'b0;
    chk("lnk_pc", link_pc, 32'h0040_0008);
    chk("lnk_vld", {31'd0, link_valid}, 32'd1);
    chk("lnk_jpc", PC0, 32'h0);
    cyc();
    chk("lnk_pulse", {31'd0, link_valid}, 32'd0);
    chk("lnk_hold", link_pc, 32'h0040_0008);
    pc_write = 1'b1;
    sel = 2'b11;
    jr_target = 32'h0000_0013;
    link = 1'b1;
    cyc();
    pc_write = 1'b0;
    link = 1'b0;
    chk("lnk_flt", {31'd0, link_valid}, 32'd0);
    do_reset();
    chk("lnk_rst", link_pc, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter owner for the multicycle CPU. Holds the architectural PC and hands it to fetch and the jump-target adder. On each control-unit write strobe it commits the next PC: sequential, branch, J-format jump, or register jump. It also tracks halt/fault state and flags misaligned register-jump targets.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on Reset; must be word-aligned.
- CLK  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high; the block is one clock domain with synchronous active-high reset.
- pc_write  in  1  control-unit strobe: commit next PC at this edge.
- sel  in  2  next-PC source: 00 PC+4, 01 branch, 10 jump, 11 register.
- branch_taken  in  1  qualifies sel=01; 0 selects PC+4.
- branch_offset  in  32  sign-extended 16-bit immediate, in words.
- jump_imm  in  26  J-format target field.
- jr_target  in  32  register-jump target.
- halt  in  1  request stop.
- PC0  out  32  current PC, registered.
- PC4  out  32  PC0+4, combinational from PC0.
- state  out  2  00 RUN, 01 HALTED, 10 FAULT.
- fault_addr  out  32  offending jr_target latched on fault.
- retire_cnt  out  32  count of committed pc_write strobes.

## Operation
- Next-PC candidates, all 32-bit and modulo 2^32:
  - seq = PC0+4.
  - branch = PC0+4+(branch_offset<<2).
  - jump = {PC0[31:28], jump_imm, 2'b00}. The region bits come from PC0, not PC4.
  - reg = jr_target.
- FSM states:
  - RUN: pc_write=1 commits the selected candidate and increments retire_cnt.
  - RUN, misaligned register jump: if sel=11 and jr_target[1:0]≠00, go to FAULT. PC0 holds, fault_addr latches jr_target, and retire_cnt does not increment.
  - RUN, halt=1: go to HALTED. If pc_write is also 1 that cycle, the commit happens first and the same edge enters HALTED.
  - HALTED: pc_write and halt are ignored and PC0 is frozen.
  - FAULT: pc_write and halt are ignored.
  - HALTED and FAULT exit only through Reset.
- Misalign and halt in the same cycle: FAULT wins.
- pc_write=0 in RUN: PC0 holds. The sel and data inputs are don't-care.
- Wrap-around: PC0=32'hFFFF_FFFC with seq gives 0.
- retire_cnt wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset values: PC0=RESET_PC, state=RUN, fault_addr=0, retire_cnt=0, link_pc=0 and link_valid=0 (when compiled in).
- Latency: the new PC appears on PC0 exactly one cycle after the edge that samples pc_write=1.
- Combinational paths: inputs to PC0 none; PC0 to PC4 only.
- Back-to-back pc_write in consecutive cycles is legal. Each commit uses the PC0 registered at that edge.
- Reset mid-operation overrides every other input on that edge, including a simultaneous pc_write.

## Configuration
- LINK_EN defined adds:
  - input link (1 bit);
  - outputs link_pc (32 bits) and link_valid (1 bit).
- Link capture: a committed pc_write with link=1 and sel∈{10,11} latches PC0+8 into link_pc (MIPS delay-slot return address) and pulses link_valid high for one cycle.
- A faulting register jump does not link.
- LINK_EN undefined: those ports do not exist and link behaviour is absent.

## Structure
- Shared package pc_pkg holds:
  - sel encodings PCSEL_SEQ/BRANCH/JUMP/REG;
  - state encodings ST_RUN/ST_HALTED/ST_FAULT;
  - the default RESET_PC constant.
- One sub-module, pc_target_mux: purely combinational. It builds the four candidates and selects per sel/branch_taken.
- FSM, PC register, counter and link register live in pc_sequencer.

## Test plan
- Reset, then 3 pc_write with sel=00 → PC0 0→4→8→C, retire_cnt=3.
- PC0=32'h1000_0040, sel=10, jump_imm=26'h0000100 → PC0=32'h1000_0400 next cycle.
- PC0=32'h0000_0100, sel=01, branch_offset=32'hFFFF_FFFC:
  - branch_taken=1 → PC0=32'h0000_00F4;
  - branch_taken=0 → PC0=32'h0000_0104.
- sel=11, jr_target=32'h0000_2002 → state=FAULT, fault_addr=32'h0000_2002, PC0 unchanged. A later pc_write is ignored and Reset recovers.
- halt with pc_write, sel=00, PC0=32'hFFFF_FFFC → PC0=0, state=HALTED, and further pc_write is ignored.
- LINK_EN defined, PC0=32'h0040_0000, sel=10, link=1 → link_pc=32'h0040_0008 and link_valid high for exactly one cycle.
